ps2_kbd_decoder: RTL
====================

// Module: ps2_kbd_decoder
// PURPOSE
//  Upstream feeder for the falling-character typing game. Receives raw PS/2 keyboard frames and tracks make/break prefixes.
//  Presents the most recent key as lowercase ASCII plus a 2-bit key state.
//  The game latches a key when state==2'b01 and applies its own hold-off, so this block reports level state and does no rate limiting.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  clk cycles without a ps2_clk falling edge before a partial frame is abandoned (2 ms at 25 MHz)
// PORTS
//  clk         in   1  system clock; all logic is on posedge clk
//  reset       in   1  synchronous, active-high
//  ps2_clk     in   1  raw keyboard clock, asynchronous
//  ps2_data    in   1  raw keyboard data, asynchronous
//  kbd_ascii   out  8  ASCII of last make code; 8'h00 if unmapped
//  state       out  2  00 idle since reset, 01 key held, 10 key released, 11 frame error
//  scan_code   out  8  last make scan code (set codes 2)
//  key_valid   out  1  one-cycle pulse per new key press
//  parity_err  out  1  one-cycle pulse per rejected frame
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs to initial state, timeout counter 0. Reset wins over any simultaneous event, including mid-frame.
//  Input sync: ps2_clk and ps2_data pass through 3-FF synchronisers.
//   fall = (sync_clk_d==1 && sync_clk==0). All sampling happens only on fall.
//  Receiver FSM: R_IDLE -> R_DATA -> R_PAR -> R_STOP -> R_IDLE.
//   R_IDLE: on fall, data==0 -> R_DATA with bit count 0. data==1 -> stay (glitch, no error).
//   R_DATA: on fall, shift data in LSB-first. After 8 bits -> R_PAR.
//   R_PAR: on fall, capture parity bit -> R_STOP.
//   R_STOP: on fall, frame ok iff stop==1 and ^{byte,parity}==1 (odd). Ok -> byte_rdy pulse next cycle; else -> err pulse next cycle. Always -> R_IDLE.
//   Timeout: in any state other than R_IDLE, the counter increments each cycle and clears on fall. At TIMEOUT_CYCLES-1 the FSM returns to R_IDLE silently with no pulse and no output change.
//  Decode FSM, advanced only on byte_rdy: D_BASE, D_BRK, D_EXT, D_EXTBRK.
//   D_BASE: F0 -> D_BRK; E0 -> D_EXT; other code = make.
//   D_EXT: F0 -> D_EXTBRK; other code = extended make with ascii forced to 00. Then -> D_BASE.
//   D_BRK / D_EXTBRK: code = break. Then -> D_BASE.
//   Make: if state==01 and code==scan_code, it is typematic repeat: nothing changes, no pulse.
//    Otherwise scan_code<=code, kbd_ascii<=table(code), state<=01, key_valid<=1.
//   Break: if code==scan_code, state<=10; otherwise ignore (release of a non-current key). kbd_ascii and scan_code are held.
//   err: parity_err<=1, state<=11, decode FSM -> D_BASE, kbd_ascii/scan_code held. The next valid make leaves 11.
//  Latency: outputs update 2 clk after the cycle in which the stop-bit fall is detected (1 cycle check, 1 cycle decode).
//  Table (ascii): letters -> 0x61..0x7A; digits -> 0x30..0x39; 29->0x20; 5A->0x0D; 66->0x08; all else 0x00. No shift/caps handling.
//  Widths: bit count 4 bits; timeout counter $clog2(TIMEOUT_CYCLES) bits, saturating; no other arithmetic.
// STRUCTURE
//  Shared package kbd_pkg: state encodings (KS_IDLE=2'b00, KS_HELD=2'b01, KS_REL=2'b10, KS_ERR=2'b11); SC_BREAK=8'hF0, SC_EXT=8'hE0; ASCII constants.
//  One sub-module: ps2_scan_to_ascii, a combinational 8-in/8-out case table, so it can be reused by the menu logic.
//  Receiver and decode FSMs stay in this module.
// TESTING
//  1. Frame 1C (start 0, data LSB-first, parity 0, stop 1) -> scan_code=1C, kbd_ascii=61, state=01, key_valid high exactly 1 cycle.
//  2. Then F0,1C -> state=10, kbd_ascii stays 61, no key_valid. Then 1C,1C,1C -> exactly one key_valid pulse, state=01.
//  3. 1C, then 32, then F0,1C -> state stays 01, kbd_ascii=62, scan_code=32; then F0,32 -> state=10.
//  4. Frame 15 with wrong parity -> parity_err 1-cycle pulse, state=11, kbd_ascii unchanged; next good 15 -> kbd_ascii=71, state=01.
//  5. 5 bits of a frame, then idle TIMEOUT_CYCLES+10 -> no pulses; next full frame 2D -> kbd_ascii=72 (no misalignment).
//  6. E0,75 -> scan_code=75, kbd_ascii=00, state=01. Reset asserted mid-frame -> all outputs 0; a following full 1C frame decodes normally.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared encodings for the PS/2 keyboard front end: key states, FSM states,
// protocol prefix codes and the ASCII values that are not plain letters/digits.
package kbd_pkg;

  typedef enum logic [1:0] {
    KS_IDLE = 2'b00,
    KS_HELD = 2'b01,
    KS_REL  = 2'b10,
    KS_ERR  = 2'b11
  } key_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_DATA = 2'b01,
    R_PAR  = 2'b10,
    R_STOP = 2'b11
  } rx_state_e;

  typedef enum logic [1:0] {
    D_BASE   = 2'b00,
    D_BRK    = 2'b01,
    D_EXT    = 2'b10,
    D_EXTBRK = 2'b11
  } dec_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational scan-code-set-2 to lowercase ASCII lookup. Unmapped codes give NUL.
module ps2_scan_to_ascii
  import kbd_pkg::*;
(
  input  logic [7:0] scan,
  output logic [7:0] ascii
);

  // Letters, digits, space, enter and backspace; everything else is NUL.
  always_comb begin
    ascii = ASCII_NUL;
    case (scan)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = ASCII_SPACE;
      8'h5A: ascii = ASCII_CR;
      8'h66: ascii = ASCII_BS;
      default: ascii = ASCII_NUL;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver plus make/break decoder. Reports the latest key as
// ASCII with a level key state; the game does its own latching and hold-off.
module ps2_kbd_decoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_ascii,
  output logic [1:0] state,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       parity_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       sync_clk, sync_data, fall;

  rx_state_e        rx_state_q, rx_state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic             err_q, err_d;
  logic [7:0]       rx_byte_q, rx_byte_d;

  dec_state_e  dec_state_q, dec_state_d;
  key_state_e  kstate_q, kstate_d;
  logic [7:0]  scan_code_q, scan_code_d;
  logic [7:0]  ascii_q, ascii_d;
  logic        key_valid_q, key_valid_d;
  logic        parity_err_q, parity_err_d;
  logic [7:0]  table_ascii;
  logic        is_make;
  logic [7:0]  make_ascii;

  ps2_scan_to_ascii u_table (
    .scan  (rx_byte_q),
    .ascii (table_ascii)
  );

  assign sync_clk  = clk_sync_q[2];
  assign sync_data = data_sync_q[2];
  assign fall      = clk_prev_q & ~sync_clk;

  // Three-flop synchronisers for the asynchronous PS/2 lines; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
      clk_prev_q  <= sync_clk;
    end
  end

  // Frame receiver: start, 8 data LSB-first, odd parity, stop; abandons stalled frames.
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = tmo_q;
    byte_rdy_d = 1'b0;
    err_d      = 1'b0;
    rx_byte_d  = rx_byte_q;
    case (rx_state_q)
      R_IDLE: begin
        if (fall && !sync_data) begin
          rx_state_d = R_DATA;
          bit_cnt_d  = 4'd0;
        end
      end
      R_DATA: begin
        if (fall) begin
          shift_d   = {sync_data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) rx_state_d = R_PAR;
        end
      end
      R_PAR: begin
        if (fall) begin
          parity_d   = sync_data;
          rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (fall) begin
          if (sync_data && (^{shift_q, parity_q})) byte_rdy_d = 1'b1;
          else                                      err_d      = 1'b1;
          rx_byte_d  = shift_q;
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
    if (rx_state_q == R_IDLE) begin
      tmo_d = '0;
    end else if (fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      rx_state_d = R_IDLE;
      tmo_d      = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      byte_rdy_q <= 1'b0;
      err_q      <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      byte_rdy_q <= byte_rdy_d;
      err_q      <= err_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // Prefix decoder: tracks F0/E0, filters typematic repeats, updates key state.
  always_comb begin
    dec_state_d  = dec_state_q;
    kstate_d     = kstate_q;
    scan_code_d  = scan_code_q;
    ascii_d      = ascii_q;
    key_valid_d  = 1'b0;
    parity_err_d = 1'b0;
    is_make      = 1'b0;
    make_ascii   = table_ascii;
    if (err_q) begin
      parity_err_d = 1'b1;
      kstate_d     = KS_ERR;
      dec_state_d  = D_BASE;
    end else if (byte_rdy_q) begin
      case (dec_state_q)
        D_BASE: begin
          if (rx_byte_q == SC_BREAK)    dec_state_d = D_BRK;
          else if (rx_byte_q == SC_EXT) dec_state_d = D_EXT;
          else                          is_make     = 1'b1;
        end
        D_EXT: begin
          if (rx_byte_q == SC_BREAK) begin
            dec_state_d = D_EXTBRK;
          end else begin
            is_make     = 1'b1;
            make_ascii  = ASCII_NUL;
            dec_state_d = D_BASE;
          end
        end
        default: begin
          if (rx_byte_q == scan_code_q) kstate_d = KS_REL;
          dec_state_d = D_BASE;
        end
      endcase
      if (is_make && !(kstate_q == KS_HELD && rx_byte_q == scan_code_q)) begin
        scan_code_d = rx_byte_q;
        ascii_d     = make_ascii;
        kstate_d    = KS_HELD;
        key_valid_d = 1'b1;
      end
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state_q  <= D_BASE;
      kstate_q     <= KS_IDLE;
      scan_code_q  <= '0;
      ascii_q      <= '0;
      key_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      dec_state_q  <= dec_state_d;
      kstate_q     <= kstate_d;
      scan_code_q  <= scan_code_d;
      ascii_q      <= ascii_d;
      key_valid_q  <= key_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign kbd_ascii  = ascii_q;
  assign state      = kstate_q;
  assign scan_code  = scan_code_q;
  assign key_valid  = key_valid_q;
  assign parity_err = parity_err_q;

endmodule
